minutnik_param: RTL and testbench

Parametrised kitchen-timer core: the time-editing, countdown and alarm logic of the minutnik, generalised in maximum setting, key-repeat rates and alarm length. It adds three things: a pause state, hold-to-repeat acceleration, and a timed alarm phase. It sits between the debounced button front-end and the 7-segment display driver. It generates all of its clock-enables internally from `i_CLK`.

---
 rtl/minutnik_pkg.sv | 24 ++
 rtl/minutnik_param_dzielnik_ce.sv | 29 ++
 rtl/minutnik_param.sv | 201 ++++++++++++++++++++
 tb/tb_minutnik_param.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minutnik_pkg.sv
// Shared definitions for the parametrised kitchen timer (minutnik).
// State encoding, button masks and time-step constants.
package minutnik_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } stan_t;

    localparam logic [3:0] BTN_IS = 4'b1000;
    localparam logic [3:0] BTN_DS = 4'b0100;
    localparam logic [3:0] BTN_IM = 4'b0010;
    localparam logic [3:0] BTN_DM = 4'b0001;

    localparam int KROK_S = 1;
    localparam int KROK_M = 60;

    function automatic int max_czas(input int max_min);
        return max_min * 60 + 59;
    endfunction

endpackage

// File: rtl/minutnik_param_dzielnik_ce.sv
// Clock-enable divider: one-cycle o_CE every DIV cycles of i_CLK.
// i_Clr holds the phase at zero and masks the enable.
module dzielnik_ce #(
    parameter int DIV = 10
) (
    input  logic i_CLK,
    input  logic i_Reset,
    input  logic i_Clr,
    output logic o_CE
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_CLK) begin
        if (i_Reset || i_Clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_CE = (cnt == LAST) && !i_Clr;

endmodule

// File: rtl/minutnik_param.sv
// Kitchen-timer core: time editing, countdown, pause and timed alarm.
// Define MINUTNIK_PAMIEC_EN to restore the last preset on return to SET.
module minutnik_param
    import minutnik_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int MAX_MIN    = 99,
    parameter int REP_HZ     = 10,
    parameter int FAST_HZ    = 50,
    parameter int ACCEL_REPS = 20,
    parameter int ALARM_S    = 10,
    localparam int MAXV      = max_czas(MAX_MIN),
    localparam int W         = $clog2(MAXV + 1)
) (
    input  logic         i_CLK,
    input  logic         i_Reset,
    input  logic [3:0]   i_Przyciski_stan,
    input  logic         i_Przyciski_impuls,
    input  logic         i_Przyciski_przytrzymanie,
    input  logic         i_Start_impuls,
    input  logic         i_Stop_impuls,
    output logic [W-1:0] o_Czas,
    output logic [1:0]   o_Stan,
    output logic         o_Alarm,
    output logic         o_Koniec_impuls
);

    localparam logic [W-1:0] MAXV_W   = W'(MAXV);
    localparam logic [W-1:0] KROK_S_W = W'(KROK_S);
    localparam logic [W-1:0] KROK_M_W = W'(KROK_M);

    localparam int RW = $clog2(ACCEL_REPS + 2);
    localparam logic [RW-1:0] ACCEL_W = RW'(ACCEL_REPS);

    localparam int AW = $clog2(ALARM_S + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_S - 1);

    stan_t         stan;
    stan_t         stan_d;
    logic [W-1:0]  czas;
    logic [W-1:0]  czas_d;
    logic [W-1:0]  czas_ed;
    logic [W-1:0]  czas_powrot;
    logic [W:0]    suma_m;
    logic [RW-1:0] rep_cnt;
    logic [AW-1:0] alarm_cnt;
    logic          tick;
    logic          slow_ce;
    logic          fast_ce;
    logic          przysp;
    logic          edit_ce;
    logic          clr_1hz;
    logic          clr_rep;

    // 1 Hz phase survives the RUN->DONE hand-over so alarm seconds align.
    assign clr_1hz = (stan != ST_RUN) && (stan != ST_DONE);
    assign clr_rep = !i_Przyciski_przytrzymanie;

    dzielnik_ce #(.DIV(CLK_HZ)) u_ce_1hz (
        .i_CLK   (i_CLK),
        .i_Reset (i_Reset),
        .i_Clr   (clr_1hz),
        .o_CE    (tick)
    );

    dzielnik_ce #(.DIV(CLK_HZ / REP_HZ)) u_ce_slow (
        .i_CLK   (i_CLK),
        .i_Reset (i_Reset),
        .i_Clr   (clr_rep),
        .o_CE    (slow_ce)
    );

    dzielnik_ce #(.DIV(CLK_HZ / FAST_HZ)) u_ce_fast (
        .i_CLK   (i_CLK),
        .i_Reset (i_Reset),
        .i_Clr   (clr_rep),
        .o_CE    (fast_ce)
    );

    assign przysp  = (rep_cnt == ACCEL_W);
    assign edit_ce = i_Przyciski_impuls
                   | (i_Przyciski_przytrzymanie & (przysp ? fast_ce : slow_ce));

    always_ff @(posedge i_CLK) begin
        if (i_Reset || clr_rep) begin
            rep_cnt <= '0;
        end else if (slow_ce && !i_Przyciski_impuls && !przysp) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_Reset || (stan != ST_DONE)) begin
            alarm_cnt <= '0;
        end else if (tick) begin
            alarm_cnt <= alarm_cnt + 1'b1;
        end
    end

`ifdef MINUTNIK_PAMIEC_EN
    logic [W-1:0] preset;

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            preset <= '0;
        end else if ((stan == ST_SET) && i_Start_impuls
                     && !i_Stop_impuls && (czas != '0)) begin
            preset <= czas;
        end
    end

    assign czas_powrot = preset;
`else
    assign czas_powrot = '0;
`endif

    assign suma_m = {1'b0, czas} + {1'b0, KROK_M_W};

    always_comb begin
        czas_ed = czas;
        if ($onehot(i_Przyciski_stan)) begin
            unique case (1'b1)
                i_Przyciski_stan[3]:
                    if (czas != MAXV_W) czas_ed = czas + KROK_S_W;
                i_Przyciski_stan[2]:
                    if (czas != '0) czas_ed = czas - KROK_S_W;
                i_Przyciski_stan[1]:
                    czas_ed = (suma_m > {1'b0, MAXV_W}) ? MAXV_W : suma_m[W-1:0];
                i_Przyciski_stan[0]:
                    czas_ed = (czas < KROK_M_W) ? '0 : czas - KROK_M_W;
                default: ;
            endcase
        end
    end

    always_comb begin
        stan_d = stan;
        czas_d = czas;
        unique case (stan)
            ST_SET: begin
                if (i_Stop_impuls) begin
                    czas_d = '0;
                end else if (i_Start_impuls && (czas != '0)) begin
                    stan_d = ST_RUN;
                end else if (edit_ce) begin
                    czas_d = czas_ed;
                end
            end
            ST_RUN: begin
                if (i_Stop_impuls) begin
                    stan_d = ST_SET;
                    czas_d = czas_powrot;
                end else if (i_Start_impuls) begin
                    stan_d = ST_PAUSE;
                end else if (tick && (czas != '0)) begin
                    czas_d = czas - KROK_S_W;
                    if (czas == KROK_S_W) stan_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (i_Stop_impuls) begin
                    stan_d = ST_SET;
                    czas_d = czas_powrot;
                end else if (i_Start_impuls && (czas != '0)) begin
                    stan_d = ST_RUN;
                end else if (edit_ce) begin
                    czas_d = czas_ed;
                end
            end
            ST_DONE: begin
                if (i_Stop_impuls || i_Start_impuls || i_Przyciski_impuls
                    || (tick && (alarm_cnt == ALARM_LAST))) begin
                    stan_d = ST_SET;
                    czas_d = czas_powrot;
                end
            end
            default: begin
                stan_d = ST_SET;
                czas_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            stan            <= ST_SET;
            czas            <= '0;
            o_Alarm         <= 1'b0;
            o_Koniec_impuls <= 1'b0;
        end else begin
            stan            <= stan_d;
            czas            <= czas_d;
            o_Alarm         <= (stan_d == ST_DONE);
            o_Koniec_impuls <= (stan_d == ST_DONE) && (stan != ST_DONE);
        end
    end

    assign o_Czas = czas;
    assign o_Stan = stan;

endmodule

// File: tb/tb_minutnik_param.sv
// Bench for minutnik_param: directed scenarios plus random stimulus,
// every cycle compared against a behavioural timer model.
module tb_minutnik_param;

    localparam int CLK_HZ  = 100;
    localparam int MAX_MIN = 99;
    localparam int REP_HZ  = 10;
    localparam int FAST_HZ = 50;
    localparam int ACCEL   = 3;
    localparam int ALARM_S = 2;
    localparam int MAXV    = MAX_MIN * 60 + 59;
    localparam int W       = $clog2(MAXV + 1);
    localparam int SLOW    = CLK_HZ / REP_HZ;
    localparam int FAST    = CLK_HZ / FAST_HZ;

    localparam int S_SET   = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    localparam logic [3:0] IS = 4'b1000;
    localparam logic [3:0] DS = 4'b0100;
    localparam logic [3:0] IM = 4'b0010;
    localparam logic [3:0] DM = 4'b0001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   btn = 4'b0;
    logic         imp = 1'b0;
    logic         hold = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] czas;
    logic [1:0]   stan;
    logic         alarm;
    logic         koniec;

    int n_chk = 0;
    int n_fail = 0;

    int m_czas = 0;
    int m_stan = S_SET;
    int m_preset = 0;
    int hold_k = 0;
    int slow_n = 0;
    int run_k = 0;
    int done_k = 0;
    int m_alarm = 0;
    int m_koniec = 0;

    minutnik_param #(
        .CLK_HZ     (CLK_HZ),
        .MAX_MIN    (MAX_MIN),
        .REP_HZ     (REP_HZ),
        .FAST_HZ    (FAST_HZ),
        .ACCEL_REPS (ACCEL),
        .ALARM_S    (ALARM_S)
    ) dut (
        .i_CLK                     (clk),
        .i_Reset                   (rst),
        .i_Przyciski_stan          (btn),
        .i_Przyciski_impuls        (imp),
        .i_Przyciski_przytrzymanie (hold),
        .i_Start_impuls            (start),
        .i_Stop_impuls             (stop),
        .o_Czas                    (czas),
        .o_Stan                    (stan),
        .o_Alarm                   (alarm),
        .o_Koniec_impuls           (koniec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int edit(input int c, input logic [3:0] b);
        if ($countones(b) != 1) return c;
        if (b[3]) return (c + 1 > MAXV) ? MAXV : c + 1;
        if (b[2]) return (c - 1 < 0) ? 0 : c - 1;
        if (b[1]) return (c + 60 > MAXV) ? MAXV : c + 60;
        return (c - 60 < 0) ? 0 : c - 60;
    endfunction

    function automatic int back();
`ifdef MINUTNIK_PAMIEC_EN
        return m_preset;
`else
        return 0;
`endif
    endfunction

    // Elapsed-time view: edges since hold began / since RUN or DONE began.
    task automatic model_step();
        int nc;
        int ns;
        bit rep;
        bit sec;
        bit alarm_end;
        if (rst) begin
            m_czas = 0; m_stan = S_SET; m_preset = 0;
            hold_k = 0; slow_n = 0; run_k = 0; done_k = 0;
            m_alarm = 0; m_koniec = 0;
            return;
        end
        rep = 1'b0;
        if (hold) begin
            hold_k++;
            if (slow_n < ACCEL) begin
                if (hold_k % SLOW == 0) begin
                    rep = 1'b1;
                    if (!imp) slow_n++;
                end
            end else begin
                rep = (hold_k % FAST == 0);
            end
        end else begin
            hold_k = 0;
            slow_n = 0;
        end
        run_k  = (m_stan == S_RUN)  ? run_k + 1  : 0;
        done_k = (m_stan == S_DONE) ? done_k + 1 : 0;
        sec       = (m_stan == S_RUN) && (run_k % CLK_HZ == 0);
        alarm_end = (m_stan == S_DONE) && (done_k == ALARM_S * CLK_HZ);
        nc = m_czas;
        ns = m_stan;
        case (m_stan)
            S_SET: begin
                if (stop) nc = 0;
                else if (start && m_czas != 0) begin
                    ns = S_RUN;
                    m_preset = m_czas;
                end else if (imp || rep) nc = edit(m_czas, btn);
            end
            S_RUN: begin
                if (stop) begin ns = S_SET; nc = back(); end
                else if (start) ns = S_PAUSE;
                else if (sec) begin
                    nc = m_czas - 1;
                    if (nc == 0) ns = S_DONE;
                end
            end
            S_PAUSE: begin
                if (stop) begin ns = S_SET; nc = back(); end
                else if (start && m_czas != 0) ns = S_RUN;
                else if (imp || rep) nc = edit(m_czas, btn);
            end
            default: begin
                if (stop || start || imp || alarm_end) begin
                    ns = S_SET;
                    nc = back();
                end
            end
        endcase
        m_koniec = (ns == S_DONE && m_stan != S_DONE) ? 1 : 0;
        m_alarm  = (ns == S_DONE) ? 1 : 0;
        m_czas = nc;
        m_stan = ns;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("czas", int'(czas), m_czas);
        check("stan", int'(stan), m_stan);
        check("alarm", int'(alarm), m_alarm);
        check("koniec", int'(koniec), m_koniec);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic press(input logic [3:0] b, input int n);
        repeat (n) begin
            btn = b; imp = 1'b1;
            cyc();
            imp = 1'b0; btn = 4'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst_czas", int'(czas), 0);
        check("rst_stan", int'(stan), S_SET);
        check("rst_alarm", int'(alarm), 0);
        check("rst_koniec", int'(koniec), 0);

        press(IS, 3);
        check("t1_is3", int'(czas), 3);
        press(IS | DS, 1);
        check("t1_multi", int'(czas), 3);
        press(DS, 4);
        check("t1_ds_floor", int'(czas), 0);

        press(IM, 99);
        press(IS, 10);
        check("t2_5950", int'(czas), 5950);
        press(IM, 1);
        check("t2_im_clamp", int'(czas), MAXV);
        press(IS, 1);
        check("t2_is_max", int'(czas), MAXV);
        pulse_stop();
        check("t2_stop", int'(czas), 0);
        press(IS, 30);
        press(DM, 1);
        check("t2_dm_clamp", int'(czas), 0);

        press(IS, 2);
        pulse_start();
        check("t3_run", int'(stan), S_RUN);
        idle(99);
        check("t3_pre1", int'(czas), 2);
        idle(1);
        check("t3_dec1", int'(czas), 1);
        idle(100);
        check("t3_zero", int'(czas), 0);
        check("t3_done", int'(stan), S_DONE);
        check("t3_koniec", int'(koniec), 1);
        check("t3_alarm", int'(alarm), 1);
        idle(1);
        check("t3_koniec1", int'(koniec), 0);
        idle(198);
        check("t3_still", int'(stan), S_DONE);
        idle(1);
        check("t3_back", int'(stan), S_SET);
        check("t3_alarm0", int'(alarm), 0);

        pulse_start();
        check("t4_start0", int'(stan), S_SET);
        press(IS, 5);
        pulse_start();
        idle(49);
        pulse_start();
        check("t4_pause", int'(stan), S_PAUSE);
        idle(300);
        check("t4_frozen", int'(czas), 5);
        pulse_start();
        idle(99);
        check("t4_pre", int'(czas), 5);
        idle(1);
        check("t4_dec", int'(czas), 4);
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("t4_ss_stan", int'(stan), S_SET);
        check("t4_ss_czas", int'(czas), 0);

        btn = IS; hold = 1'b1;
        idle(9);
        check("t5_k9", int'(czas), 0);
        idle(1);
        check("t5_k10", int'(czas), 1);
        idle(20);
        check("t5_k30", int'(czas), 3);
        idle(2);
        check("t5_k32", int'(czas), 4);
        idle(2);
        check("t5_k34", int'(czas), 5);
        hold = 1'b0; btn = 4'b0;
        idle(3);
        btn = IS; hold = 1'b1;
        idle(9);
        check("t5_re9", int'(czas), 5);
        idle(1);
        check("t5_re10", int'(czas), 6);
        hold = 1'b0; btn = 4'b0;
        idle(1);

        pulse_stop();
        press(IM, 1);
        press(IS, 30);
        pulse_start();
        pulse_stop();
        check("t6_stan", int'(stan), S_SET);
`ifdef MINUTNIK_PAMIEC_EN
        check("t6_preset", int'(czas), 90);
`else
        check("t6_clear", int'(czas), 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) begin
                hold = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) btn = 4'($urandom);
                else btn = 4'b0001 << $urandom_range(0, 3);
            end
            imp   = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
